sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, meaning address width of requester and SRAM ports.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data width of requester and SRAM ports.
REQ-003 SHALL have port HCLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports m0_HADDR / m1_HADDR  input  ADDR_W  requester byte address.
REQ-006 SHALL have ports m0_HWRITE / m1_HWRITE  input  1  1=write, 0=read.
REQ-007 SHALL have ports m0_HTRANS / m1_HTRANS  input  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a request.
REQ-008 SHALL have ports m0_HWDATA / m1_HWDATA  input  DATA_W  write data.
REQ-009 SHALL have ports m0_HRDATA / m1_HRDATA  output  DATA_W  registered read data.
REQ-010 SHALL have ports m0_HREADY / m1_HREADY  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sram_ce  output  1  SRAM access strobe.
REQ-012 SHALL have port sram_we  output  1  SRAM write enable, valid with sram_ce.
REQ-013 SHALL have port sram_addr  output  ADDR_W  SRAM address.
REQ-014 SHALL have port sram_wdata  output  DATA_W  SRAM write data.
REQ-015 SHALL have port sram_rdata  input  DATA_W  SRAM read data, valid one cycle after the cycle sram_ce=1.
REQ-016 SHALL have port gnt  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RDATA, RESP; all outputs registered.
REQ-018 Requester rule: address/write/data held stable from request until its HREADY pulse.
REQ-019 IDLE, edge with a request: load winner's addr/we/wdata to sram_*, sram_ce<=1, gnt<=winner, state<=ACCESS.
REQ-020 IDLE with no request: remain IDLE, sram_ce=0, gnt=0.
REQ-021 ACCESS: sram_ce<=0; write -> winner HREADY<=1, state<=RESP; read -> state<=RDATA.
REQ-022 RDATA: winner HRDATA<=sram_rdata, winner HREADY<=1, state<=RESP.
REQ-023 RESP: HREADY<=0, gnt<=0, state<=IDLE unconditionally; requests not sampled in RESP.
REQ-024 Latency from sampling edge to HREADY assertion: write 2 edges, read 3 edges.
REQ-025 HTRANS 2'b00/2'b01 SHALL never cause sram_ce.
REQ-026 Only one sram_ce pulse per granted transfer; non-granted HREADY stays 0; non-granted HRDATA holds last value.
REQ-027 Addresses pass unmodified, full ADDR_W range, no wrap or range check.
REQ-028 last_gnt register updated to winner on every grant.

Reset
REQ-029 HRESET=1 SHALL immediately force state=IDLE, sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, gnt=0, HREADY=0, HRDATA=0, last_gnt=M1.
REQ-030 Reset mid-transfer SHALL drop the transfer with no HREADY pulse; first edge after release behaves as IDLE.

Configuration
REQ-031 Macro SRAM_ARB_RR_EN defined: on simultaneous requests, grant the port not equal to last_gnt (round-robin; M0 wins first after reset).
REQ-032 Macro SRAM_ARB_RR_EN undefined: on simultaneous requests, M0 always wins (fixed priority); last_gnt still kept but unused.

Verification
REQ-033 Reset, m0 write addr 3 data 8'hA5 -> one cycle sram_ce=1, sram_we=1, addr 3, wdata A5, gnt=01; m0_HREADY pulses 2 edges after sampling.
REQ-034 Then m1 read addr 3 (SRAM model) -> sram_ce=1, sram_we=0, gnt=10; m1_HRDATA=A5 with m1_HREADY pulse 3 edges after sampling.
REQ-035 Both hold write requests continuously (addr 0/1) with SRAM_ARB_RR_EN -> grant order M0,M1,M0,M1; without macro -> M0 only until it drops HTRANS.
REQ-036 m0_HTRANS=2'b01, m1_HTRANS=2'b00 for 10 cycles -> sram_ce, gnt, HREADY all 0.
REQ-037 HRESET asserted during RDATA of a read -> all outputs 0 within same cycle, no HREADY pulse; after release next request served normally.
REQ-038 m0 write addr 21'h1FFFFF data 8'h5A -> sram_addr=21'h1FFFFF, sram_wdata=5A, no truncation.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous SRAM; all outputs registered.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests (default: M0 fixed priority).
module sram_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [ADDR_W-1:0] m0_HADDR,
    input  logic              m0_HWRITE,
    input  logic [1:0]        m0_HTRANS,
    input  logic [DATA_W-1:0] m0_HWDATA,
    output logic [DATA_W-1:0] m0_HRDATA,
    output logic              m0_HREADY,
    input  logic [ADDR_W-1:0] m1_HADDR,
    input  logic              m1_HWRITE,
    input  logic [1:0]        m1_HTRANS,
    input  logic [DATA_W-1:0] m1_HWDATA,
    output logic [DATA_W-1:0] m1_HRDATA,
    output logic              m1_HREADY,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

    state_t            state, state_nxt;
    logic              ce_nxt, we_nxt, rdy0_nxt, rdy1_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, rd0_nxt, rd1_nxt;
    logic [1:0]        gnt_nxt, last_gnt, last_gnt_nxt, winner;
    logic              req0, req1;
    logic              unused_trans_lsb;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign req0             = m0_HTRANS[1];
    assign req1             = m1_HTRANS[1];
    assign unused_trans_lsb = m0_HTRANS[0] ^ m1_HTRANS[0];

    always_comb begin
        winner = '0;
        if (req0 && req1) begin
`ifdef SRAM_ARB_RR_EN
            winner = (last_gnt == 2'b01) ? 2'b10 : 2'b01;
`else
            winner = 2'b01;
`endif
        end else if (req0) begin
            winner = 2'b01;
        end else if (req1) begin
            winner = 2'b10;
        end
    end

    always_comb begin
        state_nxt    = state;
        ce_nxt       = sram_ce;
        we_nxt       = sram_we;
        addr_nxt     = sram_addr;
        wdata_nxt    = sram_wdata;
        gnt_nxt      = gnt;
        last_gnt_nxt = last_gnt;
        rdy0_nxt     = 1'b0;
        rdy1_nxt     = 1'b0;
        rd0_nxt      = m0_HRDATA;
        rd1_nxt      = m1_HRDATA;
        case (state)
            IDLE: begin
                ce_nxt  = 1'b0;
                gnt_nxt = '0;
                if (winner != 2'b00) begin
                    ce_nxt       = 1'b1;
                    gnt_nxt      = winner;
                    last_gnt_nxt = winner;
                    state_nxt    = ACCESS;
                    if (winner[0]) begin
                        we_nxt    = m0_HWRITE;
                        addr_nxt  = m0_HADDR;
                        wdata_nxt = m0_HWDATA;
                    end else begin
                        we_nxt    = m1_HWRITE;
                        addr_nxt  = m1_HADDR;
                        wdata_nxt = m1_HWDATA;
                    end
                end
            end
            ACCESS: begin
                ce_nxt = 1'b0;
                if (sram_we) begin
                    rdy0_nxt  = gnt[0];
                    rdy1_nxt  = gnt[1];
                    state_nxt = RESP;
                end else begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (gnt[0]) begin
                    rd0_nxt  = sram_rdata;
                    rdy0_nxt = 1'b1;
                end
                if (gnt[1]) begin
                    rd1_nxt  = sram_rdata;
                    rdy1_nxt = 1'b1;
                end
                state_nxt = RESP;
            end
            RESP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= IDLE;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            gnt        <= '0;
            last_gnt   <= 2'b10;
            m0_HREADY  <= 1'b0;
            m1_HREADY  <= 1'b0;
            m0_HRDATA  <= '0;
            m1_HRDATA  <= '0;
        end else begin
            state      <= state_nxt;
            sram_ce    <= ce_nxt;
            sram_we    <= we_nxt;
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            gnt        <= gnt_nxt;
            last_gnt   <= last_gnt_nxt;
            m0_HREADY  <= rdy0_nxt;
            m1_HREADY  <= rdy1_nxt;
            m0_HRDATA  <= rd0_nxt;
            m1_HRDATA  <= rd1_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle table plus hand-written arbitration and reset sequences.
// Expectations follow SRAM_ARB_RR_EN when the same macro is defined for the bench.
module tb_sram_arbiter;

    logic        HCLK, HRESET;
    logic [20:0] m0_HADDR, m1_HADDR, sram_addr;
    logic        m0_HWRITE, m1_HWRITE;
    logic [1:0]  m0_HTRANS, m1_HTRANS, gnt;
    logic [7:0]  m0_HWDATA, m1_HWDATA, m0_HRDATA, m1_HRDATA;
    logic        m0_HREADY, m1_HREADY, sram_ce, sram_we;
    logic [7:0]  sram_wdata, sram_rdata;
    logic [7:0]  mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    sram_arbiter #(.ADDR_W(21), .DATA_W(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .m0_HADDR(m0_HADDR), .m0_HWRITE(m0_HWRITE), .m0_HTRANS(m0_HTRANS),
        .m0_HWDATA(m0_HWDATA), .m0_HRDATA(m0_HRDATA), .m0_HREADY(m0_HREADY),
        .m1_HADDR(m1_HADDR), .m1_HWRITE(m1_HWRITE), .m1_HTRANS(m1_HTRANS),
        .m1_HWDATA(m1_HWDATA), .m1_HRDATA(m1_HRDATA), .m1_HREADY(m1_HREADY),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .gnt(gnt)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Synchronous SRAM: read data appears the cycle after the strobe.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        sram_rdata = 8'h00;
    end
    always @(posedge HCLK) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr[3:0]] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr[3:0]];
        end
    end

    typedef struct {
        logic [1:0] t0; logic w0; logic [20:0] a0; logic [7:0] d0;
        logic [1:0] t1; logic w1; logic [20:0] a1; logic [7:0] d1;
        logic ce; logic we; logic [1:0] g; logic r0; logic r1;
        logic [20:0] addr; logic [7:0] wdata; logic [7:0] rd0; logic [7:0] rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] t0, input logic w0, input logic [20:0] a0, input logic [7:0] d0,
                       input logic [1:0] t1, input logic w1, input logic [20:0] a1, input logic [7:0] d1,
                       input logic ce, input logic we, input logic [1:0] g, input logic r0, input logic r1,
                       input logic [20:0] addr, input logic [7:0] wdata, input logic [7:0] rd0, input logic [7:0] rd1);
        vec_t v;
        v.t0 = t0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.t1 = t1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ce = ce; v.we = we; v.g = g; v.r0 = r0; v.r1 = r1;
        v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] outs();
        return {13'b0, sram_ce, sram_we, gnt, m0_HREADY, m1_HREADY, sram_addr, sram_wdata, m0_HRDATA, m1_HRDATA};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (sram_ce) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;

    logic [1:0] exp_g [4];
    bit ok;
    int lat;

    initial begin
        // Columns: m0{trans,we,addr,wdata} m1{...} | ce we gnt rdy0 rdy1 addr wdata rd0 rd1
        add(NS,1,3,8'hA5, ID,0,0,0,        1,1,2'b01,0,0, 3,8'hA5, 0,0);
        add(NS,1,3,8'hA5, ID,0,0,0,        0,1,2'b01,1,0, 3,8'hA5, 0,0);
        add(ID,1,3,8'hA5, ID,0,0,0,        0,1,2'b00,0,0, 3,8'hA5, 0,0);
        add(ID,0,0,0,     NS,0,3,0,        1,0,2'b10,0,0, 3,8'h00, 0,0);
        add(ID,0,0,0,     NS,0,3,0,        0,0,2'b10,0,0, 3,8'h00, 0,0);
        add(ID,0,0,0,     NS,0,3,0,        0,0,2'b10,0,1, 3,8'h00, 0,8'hA5);
        add(ID,0,0,0,     ID,0,3,0,        0,0,2'b00,0,0, 3,8'h00, 0,8'hA5);
        for (int i = 0; i < 10; i++)
            add(2'b01,1,7,8'hFF, ID,1,9,8'h33, 0,0,2'b00,0,0, 3,8'h00, 0,8'hA5);
        add(NS,1,21'h1FFFFF,8'h5A, ID,0,0,0, 1,1,2'b01,0,0, 21'h1FFFFF,8'h5A, 0,8'hA5);
        add(NS,1,21'h1FFFFF,8'h5A, ID,0,0,0, 0,1,2'b01,1,0, 21'h1FFFFF,8'h5A, 0,8'hA5);
        add(ID,1,21'h1FFFFF,8'h5A, ID,0,0,0, 0,1,2'b00,0,0, 21'h1FFFFF,8'h5A, 0,8'hA5);
        add(NS,0,21'h1FFFFF,8'h5A, ID,0,0,0, 1,0,2'b01,0,0, 21'h1FFFFF,8'h5A, 0,8'hA5);
        add(NS,0,21'h1FFFFF,8'h5A, ID,0,0,0, 0,0,2'b01,0,0, 21'h1FFFFF,8'h5A, 0,8'hA5);
        add(NS,0,21'h1FFFFF,8'h5A, ID,0,0,0, 0,0,2'b01,1,0, 21'h1FFFFF,8'h5A, 8'h5A,8'hA5);
        add(ID,0,21'h1FFFFF,8'h5A, ID,0,0,0, 0,0,2'b00,0,0, 21'h1FFFFF,8'h5A, 8'h5A,8'hA5);

        HRESET = 1'b1;
        m0_HTRANS = ID; m0_HWRITE = 0; m0_HADDR = '0; m0_HWDATA = '0;
        m1_HTRANS = ID; m1_HWRITE = 0; m1_HADDR = '0; m1_HWDATA = '0;
        repeat (2) tick();
        chk("reset_state", outs(), 64'h0);
        HRESET = 1'b0;

        foreach (vecs[i]) begin
            m0_HTRANS = vecs[i].t0; m0_HWRITE = vecs[i].w0; m0_HADDR = vecs[i].a0; m0_HWDATA = vecs[i].d0;
            m1_HTRANS = vecs[i].t1; m1_HWRITE = vecs[i].w1; m1_HADDR = vecs[i].a1; m1_HWDATA = vecs[i].d1;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {13'b0, vecs[i].ce, vecs[i].we, vecs[i].g, vecs[i].r0, vecs[i].r1,
                 vecs[i].addr, vecs[i].wdata, vecs[i].rd0, vecs[i].rd1});
        end

        // Both requesters hold write requests continuously after a fresh reset.
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        m0_HTRANS = NS; m0_HWRITE = 1; m0_HADDR = 21'd0; m0_HWDATA = 8'h11;
        m1_HTRANS = NS; m1_HWRITE = 1; m1_HADDR = 21'd1; m1_HWDATA = 8'h22;
`ifdef SRAM_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int g = 0; g < 4; g++) begin
            wait_ce(ok);
            chk($sformatf("contend_ce_seen%0d", g), {63'b0, ok}, 64'd1);
            chk($sformatf("contend_gnt%0d", g), {62'b0, gnt}, {62'b0, exp_g[g]});
            chk($sformatf("contend_addr%0d", g), {43'b0, sram_addr}, (exp_g[g] == 2'b01) ? 64'd0 : 64'd1);
        end
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk("contend_release", {63'b0, ok}, 64'd1);
        m0_HTRANS = ID;
        tick();
        chk("m1_after_m0_drops", {62'b0, sram_ce, gnt[1]} | {62'b0, 1'b0, gnt[0]} << 0, 64'd3);
        chk("m1_after_m0_drops_gnt", {62'b0, gnt}, 64'd2);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m1_HREADY) begin
                ok = 1'b1;
                break;
            end
        end
        chk("m1_write_done", {63'b0, ok}, 64'd1);
        m1_HTRANS = ID;
        repeat (2) tick();

        // Reset during RDATA of an m0 read from addr 3 (still A5).
        m0_HTRANS = NS; m0_HWRITE = 0; m0_HADDR = 21'd3; m0_HWDATA = 8'h00;
        tick();
        chk("rst_read_access", {62'b0, sram_ce, sram_we}, 64'd2);
        tick();
        chk("rst_read_rdata_gnt", {61'b0, sram_ce, gnt}, 64'd1);
        HRESET = 1'b1;
        #1;
        chk("async_reset_outs", outs(), 64'h0);
        tick();
        chk("reset_held_outs", outs(), 64'h0);
        HRESET = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (m0_HREADY) begin
                lat = c;
                break;
            end
        end
        chk("read_latency_after_reset", 64'(lat), 64'd3);
        chk("read_data_after_reset", {56'b0, m0_HRDATA}, 64'hA5);
        m0_HTRANS = ID;
        tick();
        chk("idle_after_read", {61'b0, gnt, m0_HREADY}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
